bus_split: RTL
==============

BUS_SPLIT -- requirements
Module: bus_split

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles to wait for m_ready per sub-access, range 2..255.
REQ-002 clk  input  1  The single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  Asynchronous reset, active-high.
REQ-004 s_valid  input  1  Upstream request; held with all s_* request fields stable until s_ready.
REQ-005 s_write  input  1  1 means write, 0 means read.
REQ-006 s_addr  input  32  Byte address; any alignment is allowed.
REQ-007 s_size  input  2  Access size: 0 = byte, 1 = halfword, 2 = word, 3 = byte.
REQ-008 s_wdata  input  32  Write data, right-justified.
REQ-009 s_ready  output  1  One-cycle completion pulse.
REQ-010 s_rdata  output  32  Read data, right-justified and zero-extended to s_size; valid while s_ready=1.
REQ-011 s_err  output  1  Asserted together with s_ready when any sub-access timed out.
REQ-012 m_valid  output  1  Downstream sub-access strobe; high for exactly one cycle per sub-access.
REQ-013 m_write, m_addr[31:0], m_size[1:0], m_wdata[31:0]  output  Downstream request fields; registered, and held stable from m_valid until m_ready or timeout.
REQ-014 m_ready  input  1  Downstream completion; m_rdata is valid in the same cycle.
REQ-015 m_rdata  input  32  Downstream read data, already shifted right by 8*m_addr[1:0].

Function
REQ-016 The block shall split each s_* request into aligned-compatible sub-accesses on a downstream port whose memory byte-enables are (size mask << addr[1:0]) truncated to 4 bits.
REQ-017 Let off = s_addr[1:0] and A4 = (s_addr & ~3) + 4; a request is misaligned if and only if it is (size 1 with off = 3) or (size 2 with off != 0).
REQ-018 Sub-access 1 shall always use m_addr = s_addr, m_size = s_size, m_wdata = s_wdata.
REQ-019 A misaligned read shall issue sub-access 2 with m_addr = A4 and m_size = 2.
REQ-020 A misaligned write shall issue sub-access 2 with m_addr = A4, m_wdata = s_wdata >> 8*(4-off), and m_size chosen by case: halfword off3 -> 0; word off1 -> 0; word off2 -> 1; word off3 -> 1.
REQ-021 A word write with off = 3 shall additionally issue sub-access 3 with m_addr = A4 + 2, m_size = 0, m_wdata = s_wdata >> 24.
REQ-022 The FSM shall have the states IDLE, ISSUE, WAIT and DONE.
REQ-023 IDLE -> ISSUE when s_valid=1; the request is latched on that edge.
REQ-024 ISSUE: m_valid=1 for one cycle, then -> WAIT.
REQ-025 WAIT on m_ready=1 or timeout: -> ISSUE if sub-accesses remain, else -> DONE.
REQ-026 DONE: s_ready=1 for one cycle, then -> IDLE; s_valid is ignored in DONE.
REQ-027 Latency: for a request first sampled at edge N, with m_ready returned one cycle after m_valid, s_ready shall go high in cycle N+3 per sub-access (i.e. cycle N+3, N+6 or N+9).
REQ-028 Read merge: result = r1 | (r2 << 8*(4-off)), truncated to 32 bits, then masked to 8 or 16 bits for sizes 0/3 or 1; r1 and r2 are the m_rdata values captured at m_ready.
REQ-029 s_rdata shall be updated only on read completion, and held otherwise, including across writes.
REQ-030 The timeout counter shall restart at each ISSUE; if WAIT lasts TIMEOUT cycles without m_ready, the sub-access is abandoned, a sticky error flag is set for the request, and its captured read data is 0.
REQ-031 m_ready outside WAIT shall be ignored.
REQ-032 m_ready arriving in the same cycle the timeout expires shall be treated as a normal completion with no error.
REQ-033 Address wrap: A4 shall be computed modulo 2^32 (e.g. s_addr = 0xFFFFFFFE word -> sub-access 2 at 0x00000000).

Reset
REQ-034 While rst=1: state = IDLE; s_ready, s_err, s_rdata, m_valid, m_write, m_addr, m_size, m_wdata and the counters = 0.
REQ-035 Reset mid-transaction shall abandon the transaction without a completion pulse, and any m_ready after reset shall be ignored.

Verification
REQ-036 Aligned word read at 0x100, mem[0x100]=0x03020100 -> one m_valid; s_ready at N+3; s_rdata=0x03020100.
REQ-037 Word read at 0x102, mem[0x104]=0x07060504 -> m_addr 0x102 then 0x104; s_rdata=0x05040302.
REQ-038 Halfword read at 0x103 -> two sub-accesses; s_rdata=0x00000403.
REQ-039 Word write 0x44332211 at 0x103 -> (0x103, size 2, 0x44332211), (0x104, size 1, 0x00443322), (0x106, size 0, 0x00000044); s_ready at N+9.
REQ-040 m_ready held low, TIMEOUT=16 -> s_ready with s_err=1, 16 cycles after m_valid plus DONE; a following aligned request completes with s_err=0.
REQ-041 rst pulsed while in WAIT of sub-access 2 -> all outputs 0 immediately; no s_ready; a late m_ready is ignored.

Source files
------------

// File: rtl/bus_split.sv
// Splits a byte-addressed request of any alignment into one to three
// downstream sub-accesses and merges misaligned read data.
module bus_split #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic        s_write,
   input  logic [31:0] s_addr,
   input  logic [1:0]  s_size,
   input  logic [31:0] s_wdata,
   output logic        s_ready,
   output logic [31:0] s_rdata,
   output logic        s_err,
   output logic        m_valid,
   output logic        m_write,
   output logic [31:0] m_addr,
   output logic [1:0]  m_size,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      r_state;
   logic        r_write;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic [31:0] r_wdata;
   logic [1:0]  r_idx;
   logic [7:0]  r_cnt;
   logic        r_err;
   logic [31:0] r_r1;

   logic [1:0]  w_off;
   logic        w_mis;
   logic [1:0]  w_last;
   logic [5:0]  w_sh;
   logic [31:0] w_a4;
   logic [1:0]  w_wsz2;
   logic [31:0] w_addr;
   logic [1:0]  w_size;
   logic [31:0] w_wdata;
   logic        w_tmo;
   logic [31:0] w_cap;
   logic [31:0] w_f1;
   logic [31:0] w_f2;
   logic [31:0] w_join;
   logic [31:0] w_merge;

   assign w_off  = r_addr[1:0];
   assign w_mis  = (r_size == 2'd1 && w_off == 2'd3) ||
                   (r_size == 2'd2 && w_off != 2'd0);
   assign w_last = !w_mis ? 2'd0 :
                   (r_write && r_size == 2'd2 && w_off == 2'd3) ? 2'd2 : 2'd1;
   assign w_sh   = {3'd4 - {1'b0, w_off}, 3'b000};
   assign w_a4   = {r_addr[31:2], 2'b00} + 32'd4;
   assign w_wsz2 = (r_size == 2'd2 && w_off != 2'd1) ? 2'd1 : 2'd0;
   assign w_tmo  = (r_cnt == 8'(TIMEOUT - 1));

   always_comb begin
      w_addr  = r_addr;
      w_size  = r_size;
      w_wdata = r_wdata;
      case (r_idx)
         2'd1: begin
            w_addr  = w_a4;
            w_size  = r_write ? w_wsz2 : 2'd2;
            w_wdata = r_wdata >> w_sh;
         end
         2'd2: begin
            w_addr  = w_a4 + 32'd2;
            w_size  = 2'd0;
            w_wdata = r_wdata >> 24;
         end
         default: ;
      endcase
   end

   // A timed-out sub-access contributes zero read data.
   assign w_cap  = m_ready ? m_rdata : 32'd0;
   assign w_f1   = (r_idx == 2'd0) ? w_cap : r_r1;
   assign w_f2   = (r_idx == 2'd1) ? w_cap : 32'd0;
   assign w_join = w_f1 | (w_f2 << w_sh);

   always_comb begin
      w_merge = w_join;
      case (r_size)
         2'd1:    w_merge = {16'd0, w_join[15:0]};
         2'd2:    w_merge = w_join;
         default: w_merge = {24'd0, w_join[7:0]};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_size  <= '0;
         r_wdata <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_r1    <= '0;
         s_ready <= 1'b0;
         s_err   <= 1'b0;
         s_rdata <= '0;
         m_valid <= 1'b0;
         m_write <= 1'b0;
         m_addr  <= '0;
         m_size  <= '0;
         m_wdata <= '0;
      end else begin
         m_valid <= 1'b0;
         s_ready <= 1'b0;
         s_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (s_valid) begin
                  r_write <= s_write;
                  r_addr  <= s_addr;
                  r_size  <= s_size;
                  r_wdata <= s_wdata;
                  r_idx   <= '0;
                  r_err   <= 1'b0;
                  r_r1    <= '0;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               m_valid <= 1'b1;
               m_write <= r_write;
               m_addr  <= w_addr;
               m_size  <= w_size;
               m_wdata <= w_wdata;
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               // m_ready wins over an expiring timeout.
               if (m_ready || w_tmo) begin
                  if (!m_ready) r_err <= 1'b1;
                  if (r_idx == 2'd0) r_r1 <= w_cap;
                  if (r_idx == w_last) begin
                     s_ready <= 1'b1;
                     s_err   <= r_err | ~m_ready;
                     if (!r_write) s_rdata <= w_merge;
                     r_state <= DONE;
                  end else begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= ISSUE;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
